// File: rtl/mem_pkg.sv
// Shared types and constants for the backing-store memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam int WORD_BYTES    = 4;
  localparam int WORD_ADDR_LSB = $clog2(WORD_BYTES);
  localparam int DATA_WIDTH    = 32;

  function automatic int index_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/memory_array.sv
// Single-port word-addressed synchronous RAM with registered read; no reset.
module memory_array
  import mem_pkg::*;
#(
  parameter int    WORDS     = 1024,
  parameter string INIT_FILE = "",
  localparam int   IW        = index_width(WORDS)
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [IW-1:0]         index,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  initial begin
    for (int unsigned i = 0; i < WORDS; i++) begin
      mem[i] = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[index] <= write_data;
    end
    read_data <= mem[index];
  end

endmodule

// File: rtl/memory_controller.sv
// Fixed-latency single-word read/write controller in front of the backing RAM.
module memory_controller
  import mem_pkg::*;
#(
  parameter int    MEMORY_WORDS = 1024,
  parameter int    LATENCY      = 4,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  request,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] input_data,
  input  logic                  should_write,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  error
);

  localparam int         IW       = index_width(MEMORY_WORDS);
  localparam int         XW       = 32 - WORD_ADDR_LSB;
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [7:0]            count;
  logic [XW-1:0]         index_in;
  logic [XW-1:0]         index_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  write_q;
  logic                  in_range;
  logic                  accept;
  logic                  access;
  logic [IW-1:0]         ram_index;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_read;

  assign index_in = XW'(address >> WORD_ADDR_LSB);
  assign in_range = ({{(32 - XW){1'b0}}, index_q} < 32'(MEMORY_WORDS));

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    access     = 1'b0;
    case (state)
      IDLE: begin
        if (request) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (count == '0) begin
          access     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The RAM is addressed from the live request while idle so its registered
  // read already holds the target word during WAIT, even when LATENCY is 1.
  assign ram_index = (state == IDLE) ? IW'(index_in) : IW'(index_q);
  assign ram_we    = access && write_q && in_range;

  memory_array #(
    .WORDS     (MEMORY_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .clock        (clock),
    .write_enable (ram_we),
    .index        (ram_index),
    .write_data   (data_q),
    .read_data    (ram_read)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      count       <= '0;
      index_q     <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      ready       <= 1'b0;
      busy        <= 1'b0;
      error       <= 1'b0;
      output_data <= '0;
    end else begin
      state <= state_next;
      ready <= access;
      busy  <= (state_next != IDLE);

      if (accept) begin
        index_q <= index_in;
        data_q  <= input_data;
        write_q <= should_write;
        count   <= CNT_LOAD;
        error   <= 1'b0;
      end else if (state == WAIT && count != '0) begin
        count <= count - 8'd1;
      end

      if (access) begin
        if (!in_range) begin
          output_data <= '0;
          error       <= 1'b1;
        end else if (write_q) begin
          output_data <= data_q;
        end else begin
          output_data <= ram_read;
        end
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Directed bench for memory_controller: LATENCY=4 instance (a) and LATENCY=1 instance (b).
module tb_memory_controller;

  logic        clock = 1'b0;
  logic        rst_a = 1'b0, req_a = 1'b0, wr_a = 1'b0;
  logic [31:0] addr_a = '0, din_a = '0, dout_a;
  logic        rdy_a, busy_a, err_a;
  logic        rst_b = 1'b0, req_b = 1'b0, wr_b = 1'b0;
  logic [31:0] addr_b = '0, din_b = '0, dout_b;
  logic        rdy_b, busy_b, err_b;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  memory_controller #(.MEMORY_WORDS(1024), .LATENCY(4), .INIT_FILE("")) dut_a (
    .clock(clock), .reset_n(rst_a), .request(req_a), .address(addr_a),
    .input_data(din_a), .should_write(wr_a), .output_data(dout_a),
    .ready(rdy_a), .busy(busy_a), .error(err_a)
  );

  memory_controller #(.MEMORY_WORDS(1024), .LATENCY(1), .INIT_FILE("")) dut_b (
    .clock(clock), .reset_n(rst_b), .request(req_b), .address(addr_b),
    .input_data(din_b), .should_write(wr_b), .output_data(dout_b),
    .ready(rdy_b), .busy(busy_b), .error(err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance a (sel=0) or b (sel=1); inputs are scrambled after
  // acceptance so only the latched copies can produce the response.
  task automatic txn(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                     input bit wr, output logic [31:0] rdata, output logic rerr,
                     output int lat, output int busy_n, output logic err_acc,
                     output logic ready_after);
    @(negedge clock);
    if (sel) begin req_b = 1'b1; addr_b = addr; din_b = wdata; wr_b = wr; end
    else     begin req_a = 1'b1; addr_a = addr; din_a = wdata; wr_a = wr; end
    @(posedge clock);
    @(negedge clock);
    if (sel) begin req_b = 1'b0; addr_b = ~addr; din_b = ~wdata; wr_b = ~wr; end
    else     begin req_a = 1'b0; addr_a = ~addr; din_a = ~wdata; wr_a = ~wr; end
    err_acc = sel ? err_b : err_a;
    lat = -1; busy_n = 0; rdata = '0; rerr = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clock);
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? rdy_b : rdy_a) begin
        lat   = n - 1;
        rdata = sel ? dout_b : dout_a;
        rerr  = sel ? err_b : err_a;
        break;
      end
    end
    @(negedge clock);
    ready_after = sel ? rdy_b : rdy_a;
    if (sel ? busy_b : busy_a) busy_n++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        re, ea, ra;
    int          lat, bn, pulses, nrdy;
    int          rpos [4];
    logic [31:0] rdat [4];

    repeat (3) @(negedge clock);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clock);
    check("reset_ready", 32'(rdy_a), 32'd0);
    check("reset_busy", 32'(busy_a), 32'd0);
    check("reset_error", 32'(err_a), 32'd0);
    check("reset_data", dout_a, 32'h0);

    // Known contents for words used later.
    txn(0, 32'h10, 32'h0, 1'b1, rd, re, lat, bn, ea, ra);
    check("pre_lat", 32'(lat), 32'd4);
    txn(0, 32'h204, 32'h1111_1111, 1'b1, rd, re, lat, bn, ea, ra);
    check("pre_echo", rd, 32'h1111_1111);
    txn(0, 32'h0, 32'h5A5A_0000, 1'b1, rd, re, lat, bn, ea, ra);
    check("pre_idx0", rd, 32'h5A5A_0000);

    // Reset one cycle into WAIT aborts a write.
    @(negedge clock);
    req_a = 1'b1; addr_a = 32'h10; din_a = 32'hDEAD_BEEF; wr_a = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_a = 1'b0;
    check("abort_busy_pre", 32'(busy_a), 32'd1);
    @(negedge clock);
    rst_a = 1'b0;
    #1;
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_ready", 32'(rdy_a), 32'd0);
    check("abort_data", dout_a, 32'h0);
    pulses = 0;
    repeat (2) begin @(negedge clock); if (rdy_a) pulses++; end
    rst_a = 1'b1;
    repeat (8) begin @(negedge clock); if (rdy_a) pulses++; end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    txn(0, 32'h10, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("abort_not_written", rd, 32'h0);

    // Write then read with ignored byte-offset bits.
    txn(0, 32'h40, 32'hCAFE_F00D, 1'b1, rd, re, lat, bn, ea, ra);
    check("wr_lat", 32'(lat), 32'd4);
    check("wr_echo", rd, 32'hCAFE_F00D);
    check("wr_err", 32'(re), 32'd0);
    check("wr_ready_1cyc", 32'(ra), 32'd0);
    check("wr_busy_cycles", 32'(bn), 32'd5);
    txn(0, 32'h42, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("rd_data", rd, 32'hCAFE_F00D);
    check("rd_lat", 32'(lat), 32'd4);

    // Out-of-range index 1024.
    txn(0, 32'h1000, 32'h1234, 1'b1, rd, re, lat, bn, ea, ra);
    check("oor_err", 32'(re), 32'd1);
    check("oor_data", rd, 32'h0);
    check("oor_err_held", 32'(err_a), 32'd1);
    txn(0, 32'h0, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("oor_clear_on_accept", 32'(ea), 32'd0);
    check("oor_idx0_intact", rd, 32'h5A5A_0000);
    check("oor_idx0_err", 32'(re), 32'd0);

    // Request held high with a new address/data every cycle.
    nrdy = 0;
    for (int e = 0; e < 22; e++) begin
      @(negedge clock);
      if (rdy_a && nrdy < 4) begin
        rpos[nrdy] = e;
        rdat[nrdy] = dout_a;
        nrdy++;
      end
      if (e < 14) begin
        req_a = 1'b1; wr_a = 1'b1;
        addr_a = 32'h200 + 32'(4 * e);
        din_a  = 32'hB000_0000 + 32'(e);
      end else begin
        req_a = 1'b0;
      end
    end
    check("hold_count", 32'(nrdy), 32'd3);
    check("hold_pos0", 32'(rpos[0]), 32'd5);
    check("hold_pos1", 32'(rpos[1]), 32'd11);
    check("hold_pos2", 32'(rpos[2]), 32'd17);
    check("hold_data0", rdat[0], 32'hB000_0000);
    check("hold_data1", rdat[1], 32'hB000_0006);
    check("hold_data2", rdat[2], 32'hB000_000C);
    txn(0, 32'h204, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("hold_ignored_word", rd, 32'h1111_1111);
    txn(0, 32'h218, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("hold_second_word", rd, 32'hB000_0006);
    txn(0, 32'h200, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("hold_first_word", rd, 32'hB000_0000);

    // LATENCY=1 boundary.
    txn(1, 32'h8, 32'h0BAD_F00D, 1'b1, rd, re, lat, bn, ea, ra);
    check("l1_wr_lat", 32'(lat), 32'd1);
    check("l1_wr_busy", 32'(bn), 32'd2);
    check("l1_wr_echo", rd, 32'h0BAD_F00D);
    txn(1, 32'h8, 32'h0, 1'b0, rd, re, lat, bn, ea, ra);
    check("l1_rd_lat", 32'(lat), 32'd1);
    check("l1_rd_busy", 32'(bn), 32'd2);
    check("l1_rd_data", rd, 32'h0BAD_F00D);
    check("l1_rd_ready_1cyc", 32'(ra), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
